vx_smem_responder: RTL and testbench

VX_SMEM_RESPONDER -- requirements
Module: VX_smem_responder

---
 rtl/vx_smem_responder.sv | 147 ++++++++++++++
 tb/tb_vx_smem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_smem_responder.sv
// vx_smem_responder
//   Banked shared-memory responder. Each cycle it picks the lowest-index
//   valid lane as the leader. It then accepts every lane that carries the
//   leader's tag and rw and that does not collide on a bank already taken
//   by a lower accepted lane. Reads of the same full address share a bank
//   (merge). Writes never merge. Reads return one registered response in
//   the following cycle.
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   req_valid/rw    : per-lane request valid, 1 = write / 0 = read
//   req_addr        : per-lane 30-bit word address
//   req_byteen/data : per-lane write byte enables and write data
//   req_tag         : per-lane tag
//   req_ready       : per-lane accept (combinational)
//   rsp_valid/tmask/data/tag : registered read response
//   rsp_ready       : response consumer ready
//   perf_conflicts  : cycles where a leader-compatible lane lost a bank
//   perf_accepts    : cycles where at least one lane fired
module vx_smem_responder #(
  parameter int NUM_LANES  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WORDS = 256,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LANES-1:0]           req_valid,
  input  logic [NUM_LANES-1:0]           req_rw,
  input  logic [NUM_LANES*30-1:0]        req_addr,
  input  logic [NUM_LANES*4-1:0]         req_byteen,
  input  logic [NUM_LANES*32-1:0]        req_data,
  input  logic [NUM_LANES*TAG_WIDTH-1:0] req_tag,
  output logic [NUM_LANES-1:0]           req_ready,
  output logic                           rsp_valid,
  output logic [NUM_LANES-1:0]           rsp_tmask,
  output logic [NUM_LANES*32-1:0]        rsp_data,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  input  logic                           rsp_ready,
  output logic [31:0]                    perf_conflicts,
  output logic [31:0]                    perf_accepts
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROW_BITS  = $clog2(BANK_WORDS);
  localparam int IDX_BITS  = BANK_BITS + ROW_BITS;

  // Flat storage: the bank field sits in the low address bits, so the low
  // IDX_BITS of an address index a word directly.
  logic [31:0] mem [NUM_BANKS*BANK_WORDS];

  logic                          stall;
  logic                          found;
  logic [TAG_WIDTH-1:0]          lead_tag;
  logic                          lead_rw;
  logic [NUM_BANKS-1:0]          claimed;
  logic [NUM_BANKS-1:0][29:0]    claim_addr;
  logic [NUM_LANES-1:0]          sel;
  logic                          conflict;
  logic [BANK_BITS-1:0]          bank;
  logic [NUM_LANES-1:0]          fire;
  logic                          read_fire;

  assign stall = rsp_valid && !rsp_ready;

  always_comb begin
    found      = 1'b0;
    lead_tag   = '0;
    lead_rw    = 1'b0;
    claimed    = '0;
    claim_addr = '0;
    sel        = '0;
    conflict   = 1'b0;
    bank       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (req_valid[i] && !found) begin
        found    = 1'b1;
        lead_tag = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        lead_rw  = req_rw[i];
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      bank = req_addr[i*30 +: BANK_BITS];
      if (req_valid[i] && (req_tag[i*TAG_WIDTH +: TAG_WIDTH] == lead_tag)
          && (req_rw[i] == lead_rw)) begin
        if (!claimed[bank]) begin
          claimed[bank]    = 1'b1;
          claim_addr[bank] = req_addr[i*30 +: 30];
          sel[i]           = 1'b1;
        end else if (!lead_rw && (claim_addr[bank] == req_addr[i*30 +: 30])) begin
          // Read of the very same word as the bank owner: share the read.
          sel[i] = 1'b1;
        end else begin
          conflict = 1'b1;
        end
      end
    end
  end

  assign req_ready = stall ? '0 : sel;
  assign fire      = req_valid & req_ready;
  assign read_fire = (|fire) && !lead_rw;

  // Storage has no reset; writes are simply suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (fire[i] && req_rw[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (req_byteen[i*4 + b])
              mem[req_addr[i*30 +: IDX_BITS]][b*8 +: 8] <= req_data[i*32 + b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_tmask <= '0;
      rsp_tag   <= '0;
      rsp_data  <= '0;
    end else if (!stall) begin
      if (read_fire) begin
        rsp_valid <= 1'b1;
        rsp_tmask <= fire;
        rsp_tag   <= lead_tag;
        for (int i = 0; i < NUM_LANES; i++)
          rsp_data[i*32 +: 32] <= fire[i] ? mem[req_addr[i*30 +: IDX_BITS]] : 32'h0;
      end else begin
        // Either the pending response just handshook or nothing was pending.
        rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflicts <= '0;
      perf_accepts   <= '0;
    end else begin
      if (conflict && !stall) perf_conflicts <= perf_conflicts + 32'd1;
      if (|fire)              perf_accepts   <= perf_accepts + 32'd1;
    end
  end

endmodule

// File: tb/tb_vx_smem_responder.sv
// tb_vx_smem_responder
//   Bench for vx_smem_responder (4 lanes, 4 banks, 256 words/bank, 8-bit tags).
//   A reference model built from the lane-selection rules tracks the
//   expected ready, response and counters every cycle.
module tb_vx_smem_responder;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_valid, req_rw;
  logic [119:0]  req_addr;
  logic [15:0]   req_byteen;
  logic [127:0]  req_data;
  logic [31:0]   req_tag;
  logic [3:0]    req_ready;
  logic          rsp_valid;
  logic [3:0]    rsp_tmask;
  logic [127:0]  rsp_data;
  logic [7:0]    rsp_tag;
  logic          rsp_ready;
  logic [31:0]   perf_conflicts, perf_accepts;

  vx_smem_responder #(.NUM_LANES(4), .NUM_BANKS(4), .BANK_WORDS(256), .TAG_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .perf_conflicts(perf_conflicts), .perf_accepts(perf_accepts)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]  mmem [1024];
  bit           m_valid;
  logic [3:0]   m_tmask;
  logic [7:0]   m_tag;
  logic [127:0] m_data;
  logic [31:0]  m_conf, m_acc;
  logic [3:0]   got_ready;

  typedef struct {
    logic [3:0]   v;
    logic [3:0]   rw;
    logic [119:0] addr;
    logic [15:0]  be;
    logic [127:0] data;
    logic [31:0]  tag;
    logic [3:0]   exp_ready;
    bit           exp_rv;
    logic [3:0]   exp_tmask;
    logic [7:0]   exp_tag;
    logic [127:0] exp_data;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [119:0] pk_addr(input int a0, input int a1, input int a2, input int a3);
    return {30'(a3), 30'(a2), 30'(a1), 30'(a0)};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] rw, input logic [119:0] addr,
                              input logic [15:0] be, input logic [127:0] data, input logic [31:0] tag,
                              input logic [3:0] er, input bit erv, input logic [3:0] etm,
                              input logic [7:0] etag, input logic [127:0] edata);
    vec_t r;
    r.v = v; r.rw = rw; r.addr = addr; r.be = be; r.data = data; r.tag = tag;
    r.exp_ready = er; r.exp_rv = erv; r.exp_tmask = etm; r.exp_tag = etag; r.exp_data = edata;
    return r;
  endfunction

  // Lane i is accepted when it agrees with the leader on tag and rw and no
  // lower accepted lane uses its bank, unless both are reads of one address.
  function automatic void model_sel(input logic [3:0] v, input logic [3:0] rw, input logic [119:0] addr,
                                    input logic [31:0] tag, output logic [3:0] sel, output bit conf,
                                    output logic [7:0] ltag, output bit lrw);
    int lead;
    bit ok;
    lead = -1; sel = 4'b0; conf = 1'b0; ltag = 8'h0; lrw = 1'b0;
    for (int i = 0; i < 4; i++) if (v[i] && lead < 0) lead = i;
    if (lead < 0) return;
    ltag = tag[lead*8 +: 8];
    lrw  = rw[lead];
    for (int i = 0; i < 4; i++) begin
      if (v[i] && tag[i*8 +: 8] == ltag && rw[i] == lrw) begin
        ok = 1'b1;
        for (int j = 0; j < i; j++)
          if (sel[j] && addr[j*30 +: 2] == addr[i*30 +: 2] &&
              (lrw || addr[j*30 +: 30] != addr[i*30 +: 30]))
            ok = 1'b0;
        sel[i] = ok;
        if (!ok) conf = 1'b1;
      end
    end
  endfunction

  task automatic check_outputs();
    chk("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      chk("rsp_tmask", rsp_tmask, m_tmask);
      chk("rsp_tag", rsp_tag, m_tag);
      chk("rsp_data", rsp_data, m_data);
    end
    chk("perf_conflicts", perf_conflicts, m_conf);
    chk("perf_accepts", perf_accepts, m_acc);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic [3:0] v, input logic [3:0] rw, input logic [119:0] addr,
                      input logic [15:0] be, input logic [127:0] data, input logic [31:0] tag,
                      input bit rr);
    logic [3:0] sel, exp_ready, fire;
    logic [7:0] ltag;
    bit conf, stall, lrw;
    req_valid = v; req_rw = rw; req_addr = addr; req_byteen = be;
    req_data = data; req_tag = tag; rsp_ready = rr;
    #1;
    model_sel(v, rw, addr, tag, sel, conf, ltag, lrw);
    stall = m_valid && !rr;
    exp_ready = stall ? 4'b0 : sel;
    got_ready = req_ready;
    chk("req_ready", req_ready, exp_ready);
    fire = v & exp_ready;
    @(posedge clk);
    if (!stall) begin
      if (fire != 4'b0 && !lrw) begin
        m_valid = 1'b1;
        m_tmask = fire;
        m_tag   = ltag;
        for (int i = 0; i < 4; i++)
          m_data[i*32 +: 32] = fire[i] ? mmem[addr[i*30 +: 10]] : 32'h0;
      end else begin
        m_valid = 1'b0;
        for (int i = 0; i < 4; i++)
          if (fire[i])
            for (int b = 0; b < 4; b++)
              if (be[i*4 + b]) mmem[addr[i*30 +: 10]][b*8 +: 8] = data[i*32 + b*8 +: 8];
      end
      if (conf) m_conf = m_conf + 32'd1;
    end
    if (fire != 4'b0) m_acc = m_acc + 32'd1;
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    req_valid = 4'b1111; req_rw = 4'b0; req_addr = pk_addr(0, 1, 2, 3);
    req_byteen = 16'h0; req_data = 128'h0; req_tag = 32'h0; rsp_ready = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      chk("reset_rsp_valid", rsp_valid, 1'b0);
    end
    reset = 1'b0;
    m_valid = 1'b0; m_tmask = 4'h0; m_tag = 8'h0; m_data = 128'h0;
    m_conf = 32'h0; m_acc = 32'h0;
  endtask

  initial begin
    logic [127:0] held_data;
    logic [3:0]   v, rw;
    logic [119:0] addr;
    logic [127:0] data;
    logic [31:0]  tag;
    logic [29:0]  a;

    tbl[0] = mk(4'hF, 4'hF, pk_addr(0, 1, 2, 3), 16'hFFFF,
                {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 32'h05050505,
                4'hF, 1'b0, 4'h0, 8'h0, 128'h0);
    tbl[1] = mk(4'hF, 4'h0, pk_addr(0, 1, 2, 3), 16'h0, 128'h0, 32'h05050505,
                4'hF, 1'b1, 4'hF, 8'h05, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    tbl[2] = mk(4'h1, 4'h1, pk_addr(8, 0, 0, 0), 16'h000F, {96'h0, 32'h11223344}, 32'h0,
                4'h1, 1'b0, 4'h0, 8'h0, 128'h0);
    tbl[3] = mk(4'h1, 4'h1, pk_addr(8, 0, 0, 0), 16'h0002, {96'h0, 32'h0000AB00}, 32'h0,
                4'h1, 1'b0, 4'h0, 8'h0, 128'h0);
    tbl[4] = mk(4'hF, 4'h0, pk_addr(8, 8, 8, 8), 16'h0, 128'h0, 32'h03030303,
                4'hF, 1'b1, 4'hF, 8'h03, {4{32'h1122AB44}});
    tbl[5] = mk(4'h0, 4'h0, pk_addr(0, 0, 0, 0), 16'h0, 128'h0, 32'h0,
                4'h0, 1'b0, 4'h0, 8'h0, 128'h0);

    // Reset with all lanes requesting.
    do_reset(2);
    chk("reset_tmask", rsp_tmask, 4'h0);
    chk("reset_tag", rsp_tag, 8'h0);
    chk("reset_data", rsp_data, 128'h0);
    chk("reset_conflicts", perf_conflicts, 32'h0);
    chk("reset_accepts", perf_accepts, 32'h0);

    // Fill words 0..15 with known contents, one word per bank per cycle.
    for (int k = 0; k < 4; k++)
      step(4'hF, 4'hF, pk_addr(4*k, 4*k+1, 4*k+2, 4*k+3), 16'hFFFF,
           {32'hC0DE0000 + 32'(4*k+3), 32'hC0DE0000 + 32'(4*k+2),
            32'hC0DE0000 + 32'(4*k+1), 32'hC0DE0000 + 32'(4*k)}, 32'h0, 1'b1);
    chk("accepts_from_zero", perf_accepts, 32'd4);

    for (int k = 0; k < 6; k++) begin
      step(tbl[k].v, tbl[k].rw, tbl[k].addr, tbl[k].be, tbl[k].data, tbl[k].tag, 1'b1);
      chk($sformatf("tbl%0d_ready", k), got_ready, tbl[k].exp_ready);
      chk($sformatf("tbl%0d_rsp_valid", k), rsp_valid, tbl[k].exp_rv);
      if (tbl[k].exp_rv) begin
        chk($sformatf("tbl%0d_tmask", k), rsp_tmask, tbl[k].exp_tmask);
        chk($sformatf("tbl%0d_tag", k), rsp_tag, tbl[k].exp_tag);
        chk($sformatf("tbl%0d_data", k), rsp_data, tbl[k].exp_data);
      end
    end

    // Bank conflict: addr 0 and addr 4 both map to bank 0.
    step(4'b0011, 4'h0, pk_addr(0, 4, 0, 0), 16'h0, 128'h0, 32'h0, 1'b1);
    chk("conf_ready1", got_ready, 4'b0001);
    chk("conf_count", perf_conflicts, 32'd1);
    chk("conf_tmask1", rsp_tmask, 4'b0001);
    chk("conf_data1", rsp_data, {96'h0, 32'hA0});
    step(4'b0010, 4'h0, pk_addr(0, 4, 0, 0), 16'h0, 128'h0, 32'h0, 1'b1);
    chk("conf_ready2", got_ready, 4'b0010);
    chk("conf_tmask2", rsp_tmask, 4'b0010);
    chk("conf_data2", rsp_data, {64'h0, 32'hC0DE0004, 32'h0});
    step(4'h0, 4'h0, 120'h0, 16'h0, 128'h0, 32'h0, 1'b1);

    // Backpressure: response held for 3 cycles, then handshake plus new read.
    step(4'b0001, 4'h0, pk_addr(1, 0, 0, 0), 16'h0, 128'h0, 32'h0, 1'b0);
    held_data = rsp_data;
    chk("bp_first_data", rsp_data, {96'h0, 32'hA1});
    for (int c = 0; c < 3; c++) begin
      step(4'b0001, 4'h0, pk_addr(2, 0, 0, 0), 16'h0, 128'h0, 32'h0, 1'b0);
      chk("bp_ready_zero", got_ready, 4'b0000);
      chk("bp_valid_held", rsp_valid, 1'b1);
      chk("bp_data_held", rsp_data, held_data);
    end
    step(4'b0001, 4'h0, pk_addr(2, 0, 0, 0), 16'h0, 128'h0, 32'h0, 1'b1);
    chk("bp_release_ready", got_ready, 4'b0001);
    chk("bp_next_valid", rsp_valid, 1'b1);
    chk("bp_next_data", rsp_data, {96'h0, 32'hA2});

    // Tag split: lane0 tag 1, lane1 tag 2, different banks.
    step(4'b0011, 4'h0, pk_addr(0, 1, 0, 0), 16'h0, 128'h0, 32'h00000201, 1'b1);
    chk("split_ready1", got_ready, 4'b0001);
    chk("split_tag1", rsp_tag, 8'd1);
    step(4'b0010, 4'h0, pk_addr(0, 1, 0, 0), 16'h0, 128'h0, 32'h00000201, 1'b1);
    chk("split_ready2", got_ready, 4'b0010);
    chk("split_tag2", rsp_tag, 8'd2);

    // Reset while a response is pending.
    step(4'b0001, 4'h0, pk_addr(3, 0, 0, 0), 16'h0, 128'h0, 32'h0, 1'b0);
    do_reset(1);
    chk("midreset_conflicts", perf_conflicts, 32'h0);
    chk("midreset_accepts", perf_accepts, 32'h0);

    // Random traffic over words 0..15 with occasional aliasing high bits.
    for (int n = 0; n < 3000; n++) begin
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) rw = {4{1'($urandom_range(0, 1))}};
      else rw = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        a = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0, 6'h0, 4'($urandom_range(0, 15))};
        if (i > 0 && $urandom_range(0, 2) == 0) a = addr[29:0];
        addr[i*30 +: 30] = a;
        data[i*32 +: 32] = $urandom;
        tag[i*8 +: 8] = 8'($urandom_range(0, 1));
      end
      step(v, rw, addr, 16'($urandom_range(0, 65535)), data, tag, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
